// File: rtl/grah8_alu_pkg.sv
// Shared ALU command definitions for the encoder and decoder sides:
// opcodes, request bit positions and encoder FSM states.
package grah8_alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t OP_NOP  = 4'd0;
   localparam alu_op_t OP_ADD  = 4'd1;
   localparam alu_op_t OP_SUB  = 4'd2;
   localparam alu_op_t OP_NOT  = 4'd3;
   localparam alu_op_t OP_OR   = 4'd4;
   localparam alu_op_t OP_NOR  = 4'd5;
   localparam alu_op_t OP_XOR  = 4'd6;
   localparam alu_op_t OP_NXOR = 4'd7;
   localparam alu_op_t OP_AND  = 4'd8;
   localparam alu_op_t OP_NAND = 4'd9;
   localparam alu_op_t OP_MUL  = 4'd10;
   localparam alu_op_t OP_DIV  = 4'd11;

   localparam int REQ_ADD  = 0;
   localparam int REQ_SUB  = 1;
   localparam int REQ_NOT  = 2;
   localparam int REQ_OR   = 3;
   localparam int REQ_NOR  = 4;
   localparam int REQ_XOR  = 5;
   localparam int REQ_NXOR = 6;
   localparam int REQ_AND  = 7;
   localparam int REQ_NAND = 8;
   localparam int REQ_MUL  = 9;
   localparam int REQ_DIV  = 10;
   localparam int REQ_W    = 11;

   typedef logic [REQ_W-1:0] alu_req_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_STALL
   } enc_state_t;

   // Request bit i maps to opcode i+1; the lowest set bit wins.
   function automatic alu_op_t req_to_op(alu_req_t r);
      alu_op_t op;
      op = OP_NOP;
      for (int i = REQ_W - 1; i >= 0; i--) begin
         if (r[i]) op = alu_op_t'(i + 1);
      end
      return op;
   endfunction

   function automatic logic is_muldiv(alu_op_t op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_cmd_encoder_cmd_fifo.sv
// cmd_fifo: synchronous DEPTH x W FIFO with wrap-bit pointers,
// push/pop/full/empty and occupancy level.
module cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem [DEPTH];
   logic [LW-1:0] wptr_q, wptr_d;
   logic [LW-1:0] rptr_q, rptr_d;
   logic          push_ok, pop_ok;

   always_comb begin
      level   = wptr_q - rptr_q;
      empty   = (wptr_q == rptr_q);
      full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      wptr_d  = wptr_q + LW'(push_ok);
      rptr_d  = rptr_q + LW'(pop_ok);
      head    = mem[rptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_cmd_encoder.sv
// ALU command encoder: one-hot requests -> queued 4-bit opcodes with mul/div stall.
// Define ALU_CMD_ENCODER_PRIORITY_EN to encode multi-hot requests by lowest set bit.
module alu_cmd_encoder
   import grah8_alu_pkg::*;
#(
   parameter  int DEPTH       = 4,
   parameter  int MULDIV_WAIT = 3,
   localparam int LW          = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  alu_req_t      req,
   input  logic          req_valid,
   output logic          req_ready,
   output logic [7:0]    instruction,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic          dec_disable,
   output logic          err,
   output logic [LW-1:0] level
);

   localparam int CW = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT + 1) : 1;

   enc_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   alu_op_t       enc_op;
   alu_op_t       head;
   logic          full, empty;
   logic          accept, push, pop;
   logic [LW-1:0] lvl_nxt;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (4)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (enc_op),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .level (level),
      .head  (head)
   );

   always_comb begin
`ifdef ALU_CMD_ENCODER_PRIORITY_EN
      enc_op = req_to_op(req);
`else
      enc_op = $onehot(req) ? req_to_op(req) : OP_NOP;
`endif
      req_ready   = !rst && !full;
      accept      = req_valid && req_ready;
      push        = accept && (enc_op != OP_NOP);
      err_d       = accept && (enc_op == OP_NOP);
      instr_valid = (state_q == ST_ISSUE) && !empty;
      pop         = instr_valid && instr_ready;
      lvl_nxt     = level + LW'(push) - LW'(pop);
      instruction = instr_valid ? {4'b0000, head} : 8'h00;
      dec_disable = !instr_valid;
      err         = err_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (lvl_nxt != '0) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (pop && is_muldiv(head) && (MULDIV_WAIT > 0)) begin
               state_d = ST_STALL;
               cnt_d   = CW'(MULDIV_WAIT);
            end else if (lvl_nxt == '0) begin
               state_d = ST_IDLE;
            end
         end
         ST_STALL: begin
            cnt_d = cnt_q - CW'(1);
            // Last stall cycle: resume on whatever will be queued after this edge.
            if (cnt_q == CW'(1)) begin
               state_d = (lvl_nxt != '0) ? ST_ISSUE : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_cmd_encoder.sv
// Self-checking bench for alu_cmd_encoder: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_cmd_encoder;

   localparam int DEPTH = 4;
   localparam int WAIT  = 3;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [10:0]   req = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [7:0]    instruction;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic          dec_disable;
   logic          err;
   logic [LW-1:0] level;

   int checks = 0;
   int errors = 0;

   int q[$];
   int stall = 0;
   bit err_m = 1'b0;

   alu_cmd_encoder #(
      .DEPTH       (DEPTH),
      .MULDIV_WAIT (WAIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .dec_disable (dec_disable),
      .err         (err),
      .level       (level)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Opcode the spec assigns to a request; 0 means dropped with err.
   function automatic int enc(logic [10:0] r);
      int n;
      n = $countones(r);
      if (n == 0) return 0;
`ifndef ALU_CMD_ENCODER_PRIORITY_EN
      if (n > 1) return 0;
`endif
      for (int i = 0; i < 11; i++) begin
         if (r[i]) return i + 1;
      end
      return 0;
   endfunction

   function automatic bit m_valid();
      return (q.size() > 0) && (stall == 0);
   endfunction

   task automatic model_update();
      bit v;
      bit rdy;
      int h;
      int op;
      if (rst) begin
         q.delete();
         stall = 0;
         err_m = 1'b0;
         return;
      end
      v   = m_valid();
      rdy = q.size() < DEPTH;
      if (stall > 0) stall--;
      if (v && instr_ready) begin
         h = q.pop_front();
         if ((h == 10 || h == 11) && WAIT > 0) stall = WAIT;
      end
      err_m = 1'b0;
      if (req_valid && rdy) begin
         op = enc(req);
         if (op == 0) err_m = 1'b1;
         else q.push_back(op);
      end
   endtask

   task automatic compare_all();
      bit v;
      v = m_valid();
      chk("instruction", instruction, v ? q[0] : 0);
      chk("instr_valid", instr_valid, v);
      chk("disable", dec_disable, !v);
      chk("req_ready", req_ready, !rst && (q.size() < DEPTH));
      chk("err", err, err_m);
      chk("level", level, q.size());
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic put(int idx);
      req       = 11'(1) << idx;
      req_valid = 1'b1;
      step();
   endtask

   initial begin
      int r;
      // Reset then idle
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_instr", instruction, 8'h00);
      chk("rst_disable", dec_disable, 1);
      chk("rst_ready", req_ready, 1);
      chk("rst_level", level, 0);

      // Single add
      instr_ready = 1'b1;
      put(0);
      req_valid = 1'b0;
      chk("single_instr", instruction, 8'h01);
      chk("single_valid", instr_valid, 1);
      chk("single_dis", dec_disable, 0);
      step();
      chk("single_after", dec_disable, 1);

      // Fill with backpressure
      instr_ready = 1'b0;
      put(1);
      put(3);
      put(5);
      put(8);
      chk("fill_level", level, 4);
      chk("fill_ready", req_ready, 0);
      put(0);
      chk("fill_5th", level, 4);
      req_valid   = 1'b0;
      instr_ready = 1'b1;
      chk("drain0", instruction, 8'h02);
      step();
      chk("drain1", instruction, 8'h04);
      step();
      chk("drain2", instruction, 8'h06);
      step();
      chk("drain3", instruction, 8'h09);
      step();
      chk("drain_end", dec_disable, 1);

      // Mul stall
      put(9);
      chk("mul_instr", instruction, 8'h0A);
      put(0);
      req_valid = 1'b0;
      chk("stall1", dec_disable, 1);
      step();
      chk("stall2", dec_disable, 1);
      step();
      chk("stall3", dec_disable, 1);
      step();
      chk("after_stall", instruction, 8'h01);
      step();

      // Malformed requests
      req       = 11'h000;
      req_valid = 1'b1;
      step();
      chk("zero_err", err, 1);
      chk("zero_level", level, 0);
      req = 11'h003;
      step();
      req_valid = 1'b0;
`ifdef ALU_CMD_ENCODER_PRIORITY_EN
      chk("multi_err", err, 0);
      chk("multi_instr", instruction, 8'h01);
`else
      chk("multi_err", err, 1);
      chk("multi_level", level, 0);
`endif
      step();
      chk("err_pulse", err, 0);
      step();

      // Reset during stall with a full queue behind it
      instr_ready = 1'b0;
      put(9);
      put(1);
      put(3);
      put(7);
      req_valid   = 1'b0;
      instr_ready = 1'b1;
      step();
      chk("mid_level", level, 3);
      chk("mid_stall", dec_disable, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_dis", dec_disable, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("no_stale", instr_valid, 0);
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7) req = 11'(1) << $urandom_range(0, 10);
         else if (r == 7) req = '0;
         else req = 11'($urandom);
         req_valid   = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 2) != 0);
         rst         = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
